minimizer_scheduler: RTL and testbench

Sequences minimizer extraction over a stream of k-mer hash values. Holds a sliding window of the most recent WINDOW hashes and, for every full window, runs a sequential one-entry-per-cycle minimum scan. Reports the window minimum and its position through a valid/ready handshake. Sits between the k-mer hashing stage and the seed/minimizer consumer, replacing the single-shot 49-wide minimum search with a streaming, back-pressured controller.

---
 rtl/minimizer_pkg.sv | 16 +
 rtl/window_ring_buf.sv | 56 +++++
 rtl/minimizer_scheduler.sv | 127 ++++++++++++
 tb/tb_minimizer_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/minimizer_pkg.sv
// Shared defaults and types for the minimizer scheduler slice.
package minimizer_pkg;

  localparam int DEF_WINDOW = 49;
  localparam int DEF_HASH_W = 32;
  localparam int DEF_IDX_W  = $clog2(DEF_WINDOW);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  typedef logic [DEF_HASH_W-1:0] hash_t;

endpackage

// File: rtl/window_ring_buf.sv
// Circular window storage: one write port, saturating fill counter and a
// read port addressed by logical offset from the oldest entry.
module window_ring_buf
  import minimizer_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int HASH_W = DEF_HASH_W,
  parameter int IDX_W  = $clog2(WINDOW),
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              clear,
  input  logic              wrEn,
  input  logic [HASH_W-1:0] wrData,
  input  logic [IDX_W-1:0]  rdIdx,
  output logic [HASH_W-1:0] rdData,
  output logic [CNT_W-1:0]  fillCnt
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WINDOW);
  localparam logic [IDX_W:0]   WRAP     = (IDX_W + 1)'(WINDOW);

  logic [HASH_W-1:0] mem [WINDOW];
  logic [IDX_W-1:0]  wrPtr;
  logic [IDX_W:0]    rdSum;
  logic [IDX_W-1:0]  rdAddr;

  // Write pointer wraps at WINDOW-1; once full, wrPtr also marks the oldest entry.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr   <= '0;
      fillCnt <= '0;
    end else if (clear) begin
      wrPtr   <= '0;
      fillCnt <= '0;
    end else if (wrEn) begin
      wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + IDX_W'(1);
      if (fillCnt != FULL_CNT) fillCnt <= fillCnt + CNT_W'(1);
    end
  end

  // Storage contents need no reset; fillCnt says what is meaningful.
  always_ff @(posedge clk) begin
    if (wrEn && !clear) mem[wrPtr] <= wrData;
  end

  // Logical offset to physical slot: (wrPtr + rdIdx) mod WINDOW.
  always_comb begin
    rdSum  = {1'b0, wrPtr} + {1'b0, rdIdx};
    rdAddr = (rdSum >= WRAP) ? IDX_W'(rdSum - WRAP) : rdSum[IDX_W-1:0];
    rdData = mem[rdAddr];
  end

endmodule

// File: rtl/minimizer_scheduler.sv
// Streaming minimizer controller: fills a sliding window of hashes, scans it
// oldest-first one entry per cycle and hands out the minimum via valid/ready.
//
// state | meaning
// FILL  | accepting hashes until the window is (re)completed
// SCAN  | sequential strict-less minimum search, oldest entry first
// EMIT  | result held on minVal/minPos until minReady
module minimizer_scheduler
  import minimizer_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int HASH_W = DEF_HASH_W,
  parameter int IDX_W  = $clog2(WINDOW)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              flush,
  input  logic [HASH_W-1:0] hashIn,
  input  logic              hashValid,
  output logic              hashReady,
  output logic [HASH_W-1:0] minVal,
  output logic [IDX_W-1:0]  minPos,
  output logic              minValid,
  input  logic              minReady,
  output logic              busy
);

  localparam int              CNT_W     = $clog2(WINDOW + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  state_t            state;
  logic [IDX_W-1:0]  scanIdx;
  logic [HASH_W-1:0] runMin;
  logic [IDX_W-1:0]  runPos;
  logic [HASH_W-1:0] rdData;
  logic [CNT_W-1:0]  fillCnt;
  logic              accept;
  logic              completes;
  logic              isLess;
  logic [HASH_W-1:0] nextMin;
  logic [IDX_W-1:0]  nextPos;

  assign hashReady = (state == FILL) && !flush;
  assign accept    = hashValid && hashReady;
  // Full window before this accept, or last slot being filled now.
  assign completes = (fillCnt >= LAST_CNT);

  window_ring_buf #(
    .WINDOW (WINDOW),
    .HASH_W (HASH_W),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_ring (
    .clk     (clk),
    .rstN    (rstN),
    .clear   (flush),
    .wrEn    (accept),
    .wrData  (hashIn),
    .rdIdx   (scanIdx),
    .rdData  (rdData),
    .fillCnt (fillCnt)
  );

  // Strict-less replace keeps the oldest entry on ties.
  always_comb begin
    isLess  = (rdData < runMin);
    nextMin = isLess ? rdData : runMin;
    nextPos = isLess ? scanIdx : runPos;
  end

  // Sequencer with registered result and busy; flush overrides every transition.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= FILL;
      scanIdx  <= '0;
      runMin   <= '1;
      runPos   <= '0;
      minVal   <= '0;
      minPos   <= '0;
      minValid <= 1'b0;
      busy     <= 1'b0;
    end else if (flush) begin
      state    <= FILL;
      scanIdx  <= '0;
      minValid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept && completes) begin
            state   <= SCAN;
            busy    <= 1'b1;
            scanIdx <= '0;
            runMin  <= '1;
            runPos  <= '0;
          end
        end
        SCAN: begin
          if (scanIdx == LAST_IDX) begin
            minVal   <= nextMin;
            minPos   <= nextPos;
            minValid <= 1'b1;
            state    <= EMIT;
          end else begin
            runMin  <= nextMin;
            runPos  <= nextPos;
            scanIdx <= scanIdx + IDX_W'(1);
          end
        end
        EMIT: begin
          if (minReady) begin
            minValid <= 1'b0;
            busy     <= 1'b0;
            state    <= FILL;
          end
        end
        default: begin
          state    <= FILL;
          minValid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minimizer_scheduler.sv
// Self-checking bench for minimizer_scheduler: directed window/slide/tie,
// backpressure, flush and async-reset sequences plus randomized streams
// compared against a queue-based window model.
module tb_minimizer_scheduler;
  import minimizer_pkg::*;

  localparam int W = DEF_WINDOW;

  logic                 clk = 1'b0;
  logic                 rstN;
  logic                 flush;
  hash_t                hashIn;
  logic                 hashValid;
  logic                 hashReady;
  hash_t                minVal;
  logic [DEF_IDX_W-1:0] minPos;
  logic                 minValid;
  logic                 minReady;
  logic                 busy;

  minimizer_scheduler #(
    .WINDOW (W),
    .HASH_W (DEF_HASH_W),
    .IDX_W  (DEF_IDX_W)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .flush     (flush),
    .hashIn    (hashIn),
    .hashValid (hashValid),
    .hashReady (hashReady),
    .minVal    (minVal),
    .minPos    (minPos),
    .minValid  (minValid),
    .minReady  (minReady),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  hash_t win[$];

  typedef struct {
    hash_t hin;
    hash_t expVal;
    int    expPos;
  } slide_t;
  slide_t slides[5];

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  // Window minimum by definition: first (oldest) occurrence of the smallest value.
  function automatic void refMin(output hash_t v, output int p);
    v = '1;
    p = 0;
    foreach (win[i]) if (win[i] < v) begin v = win[i]; p = i; end
  endfunction

  task automatic accept(input hash_t h);
    #1;
    check("hashReady before accept", hashReady, 1);
    hashIn = h;
    hashValid = 1'b1;
    @(negedge clk);
    hashValid = 1'b0;
    hashIn = hash_t'($urandom);
    win.push_back(h);
    if (win.size() > W) void'(win.pop_front());
  endtask

  task automatic doFlush();
    flush = 1'b1;
    #1;
    check("hashReady low during flush", hashReady, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("minValid after flush", minValid, 0);
    check("hashReady after flush", hashReady, 1);
    win.delete();
  endtask

  task automatic waitValid(output int cyc);
    cyc = 0;
    while (!minValid && cyc < 2 * W + 10) begin
      check("hashReady low while scanning", hashReady, 0);
      @(negedge clk);
      cyc++;
    end
    check("minValid arrives", minValid, 1);
  endtask

  task automatic getResult(input int expLat, input int hold, input bit dropByFlush,
                           output hash_t v, output int p);
    int    cyc;
    hash_t rv;
    int    rp;
    waitValid(cyc);
    v = minVal;
    p = int'(minPos);
    if (!minValid) return;
    if (expLat >= 0) check("latency", cyc, expLat);
    check("busy in EMIT", busy, 1);
    check("hashReady in EMIT", hashReady, 0);
    refMin(rv, rp);
    check("minVal vs model", minVal, rv);
    check("minPos vs model", minPos, rp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("held minValid", minValid, 1);
      check("held minVal", minVal, v);
      check("held minPos", minPos, p);
      check("held hashReady", hashReady, 0);
    end
    if (dropByFlush) begin
      doFlush();
    end else begin
      minReady = 1'b1;
      @(negedge clk);
      minReady = 1'b0;
      check("minValid after handshake", minValid, 0);
      check("busy after handshake", busy, 0);
      check("hashReady after handshake", hashReady, 1);
    end
  endtask

  initial begin
    hash_t v;
    int    p;
    int    cyc;
    int    seen;

    slides[0] = '{hin: 10,  expVal: 10, expPos: 48};
    slides[1] = '{hin: 200, expVal: 10, expPos: 47};
    slides[2] = '{hin: 5,   expVal: 5,  expPos: 48};
    slides[3] = '{hin: 5,   expVal: 5,  expPos: 47};
    slides[4] = '{hin: 300, expVal: 5,  expPos: 46};

    rstN = 1'b0; flush = 1'b0; hashValid = 1'b0; minReady = 1'b0; hashIn = '0;
    repeat (2) @(negedge clk);
    check("reset minVal", minVal, 0);
    check("reset minPos", minPos, 0);
    check("reset minValid", minValid, 0);
    check("reset busy", busy, 0);
    check("reset hashReady", hashReady, 1);
    rstN = 1'b1;
    @(negedge clk);
    check("post-reset hashReady", hashReady, 1);

    // First window: 100..52, minimum is the newest entry.
    for (int i = 0; i < W; i++) accept(hash_t'(100 - i));
    getResult(W, 0, 1'b0, v, p);
    check("first window val", v, 52);
    check("first window pos", p, 48);

    // Slide: each accept evicts the oldest entry; first one also holds 20 cycles.
    for (int i = 0; i < 5; i++) begin
      accept(slides[i].hin);
      getResult(W, (i == 0) ? 20 : 0, 1'b0, v, p);
      check("slide val", v, slides[i].expVal);
      check("slide pos", p, slides[i].expPos);
    end

    // Ties: oldest wins.
    doFlush();
    for (int i = 0; i < W; i++) accept(hash_t'(7));
    getResult(W, 0, 1'b0, v, p);
    check("tie val", v, 7);
    check("tie pos", p, 0);

    // Flush at scan step 20.
    doFlush();
    for (int i = 0; i < W; i++) accept(hash_t'($urandom_range(1, 5)));
    repeat (20) @(negedge clk);
    check("busy mid-scan", busy, 1);
    doFlush();
    seen = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (minValid) seen++;
    end
    check("no result after scan flush", seen, 0);
    for (int i = 0; i < W; i++) accept(hash_t'(1000 + $urandom_range(0, 500)));
    getResult(W, 0, 1'b0, v, p);
    check("post-flush result uses fresh hashes", (v >= 1000), 1);

    // Async reset while in EMIT, between edges.
    doFlush();
    for (int i = 0; i < W; i++) accept(hash_t'(100 - i));
    waitValid(cyc);
    #2 rstN = 1'b0;
    #1;
    check("async reset minValid", minValid, 0);
    check("async reset minVal", minVal, 0);
    check("async reset minPos", minPos, 0);
    check("async reset busy", busy, 0);
    check("async reset hashReady", hashReady, 1);
    #1 rstN = 1'b1;
    @(negedge clk);
    win.delete();
    for (int i = 0; i < W; i++) accept(hash_t'(100 - i));
    getResult(W, 0, 1'b0, v, p);
    check("after reset val", v, 52);
    check("after reset pos", p, 48);

    // Randomized stream with small values (frequent ties), holds, flushes.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 24) == 0) doFlush();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      accept(hash_t'($urandom_range(0, 15)));
      if (win.size() == W)
        getResult(W, $urandom_range(0, 3), ($urandom_range(0, 11) == 0), v, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
